odd_count_checker: RTL and testbench

Receive-side companion to the odd-sequence counter. Samples a 4-bit count stream on a strobe and checks that it follows the legal cycle 1,3,5,7,9,1,… It locks onto the sequence and then flywheels through isolated glitches. While locked it flags every mismatch, counts errors and completed wraps, and drops lock after repeated misses. It sits at the far end of the counter's output bus and feeds status LEDs and debug registers.

---
 rtl/odd_count_checker.sv | 121 ++++++++++++
 tb/tb_odd_count_checker.sv | 184 ++++++++++++++++++
 2 files changed

// File: rtl/odd_count_checker.sv
// Receive-side checker for the 1,3,5,7,9 odd count stream: locks onto the
// sequence, flywheels through isolated glitches, and tracks errors and wraps.
module odd_count_checker #(
   parameter int LOCK_LEN = 3,
   parameter int MAX_ERR  = 2
) (
   input  logic       Clk,
   input  logic       reset,
   input  logic [3:0] Count_in,
   input  logic       valid_in,
   output logic       locked,
   output logic       error,
   output logic       wrap,
   output logic [3:0] expected,
   output logic [7:0] err_count,
   output logic [7:0] wrap_count
);

   typedef enum logic [1:0] {SEARCH, LOCKING, LOCKED} state_t;

   localparam logic [3:0] LOCK_LEN_C = 4'(LOCK_LEN);
   localparam logic [3:0] MAX_ERR_C  = 4'(MAX_ERR);

   state_t     r_state, w_state_nxt;
   logic [3:0] r_run, r_miss;
   logic [3:0] w_run_nxt, w_miss_nxt, w_exp_nxt;
   logic [7:0] w_errc_nxt, w_wrapc_nxt;
   logic       w_err_nxt, w_wrap_nxt, w_legal, w_match;

   function automatic logic [3:0] f_next(input logic [3:0] v);
      return (v == 4'd9) ? 4'd1 : v + 4'd2;
   endfunction

   assign w_legal = Count_in[0] && (Count_in <= 4'd9);
   assign w_match = (Count_in == expected);

   always_comb begin
      w_state_nxt = r_state;
      w_run_nxt   = r_run;
      w_miss_nxt  = r_miss;
      w_exp_nxt   = expected;
      w_err_nxt   = 1'b0;
      w_wrap_nxt  = 1'b0;
      w_errc_nxt  = err_count;
      w_wrapc_nxt = wrap_count;
      if (valid_in) begin
         case (r_state)
            SEARCH: begin
               if (w_legal) begin
                  w_state_nxt = LOCKING;
                  w_run_nxt   = 4'd1;
                  w_exp_nxt   = f_next(Count_in);
               end
            end
            LOCKING: begin
               if (w_match) begin
                  w_run_nxt = r_run + 4'd1;
                  w_exp_nxt = f_next(Count_in);
                  if (r_run + 4'd1 == LOCK_LEN_C) begin
                     w_state_nxt = LOCKED;
                     w_miss_nxt  = 4'd0;
                  end
               end else if (w_legal) begin
                  w_run_nxt = 4'd1;
                  w_exp_nxt = f_next(Count_in);
               end else begin
                  w_state_nxt = SEARCH;
                  w_run_nxt   = 4'd0;
               end
            end
            LOCKED: begin
               if (w_match) begin
                  w_exp_nxt  = f_next(Count_in);
                  w_miss_nxt = 4'd0;
                  if (Count_in == 4'd9) begin
                     w_wrap_nxt  = 1'b1;
                     w_wrapc_nxt = wrap_count + 8'd1;
                  end
               end else begin
                  // Flywheel: advance the prediction, ignore the bad sample.
                  w_err_nxt  = 1'b1;
                  w_exp_nxt  = f_next(expected);
                  w_miss_nxt = r_miss + 4'd1;
                  if (err_count != 8'hFF) w_errc_nxt = err_count + 8'd1;
                  if (r_miss + 4'd1 == MAX_ERR_C) begin
                     w_state_nxt = SEARCH;
                     w_run_nxt   = 4'd0;
                     w_miss_nxt  = 4'd0;
                  end
               end
            end
            default: w_state_nxt = SEARCH;
         endcase
      end
   end

   always_ff @(posedge Clk) begin
      if (reset) begin
         r_state    <= SEARCH;
         r_run      <= 4'd0;
         r_miss     <= 4'd0;
         expected   <= 4'd1;
         locked     <= 1'b0;
         error      <= 1'b0;
         wrap       <= 1'b0;
         err_count  <= 8'd0;
         wrap_count <= 8'd0;
      end else begin
         r_state    <= w_state_nxt;
         r_run      <= w_run_nxt;
         r_miss     <= w_miss_nxt;
         expected   <= w_exp_nxt;
         locked     <= (w_state_nxt == LOCKED);
         error      <= w_err_nxt;
         wrap       <= w_wrap_nxt;
         err_count  <= w_errc_nxt;
         wrap_count <= w_wrapc_nxt;
      end
   end

endmodule

// File: tb/tb_odd_count_checker.sv
// Directed bench for odd_count_checker: a sample-level reference model is
// compared against the DUT every cycle, plus hand-computed spot checks.
module tb_odd_count_checker;

   localparam int LOCK_LEN = 3;
   localparam int MAX_ERR  = 2;

   logic       Clk = 1'b0;
   logic       reset = 1'b1;
   logic [3:0] Count_in = 4'd5;
   logic       valid_in = 1'b1;
   logic       locked, error, wrap;
   logic [3:0] expected;
   logic [7:0] err_count, wrap_count;

   odd_count_checker #(.LOCK_LEN(LOCK_LEN), .MAX_ERR(MAX_ERR)) dut (
      .Clk(Clk), .reset(reset), .Count_in(Count_in), .valid_in(valid_in),
      .locked(locked), .error(error), .wrap(wrap), .expected(expected),
      .err_count(err_count), .wrap_count(wrap_count)
   );

   always #5 Clk = ~Clk;

   int tests = 0, fails = 0;
   bit chk_en = 1'b0;

   // Reference: 0 = hunting, 1 = building confidence, 2 = locked
   int m_mode = 0, m_run = 0, m_miss = 0, m_exp = 1, m_errc = 0, m_wrapc = 0;
   bit m_err = 0, m_wrap = 0;

   function automatic int nxt(input int v);
      return (v + 1) % 10 + 1;
   endfunction

   function automatic bit legal(input int v);
      return v inside {1, 3, 5, 7, 9};
   endfunction

   task automatic check(input string nm, input int act, input int exp);
      tests++;
      if (act != exp) begin
         fails++;
         $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
      end
   endtask

   task automatic model(input bit r, input bit v, input int c);
      m_err = 0; m_wrap = 0;
      if (r) begin
         m_mode = 0; m_run = 0; m_miss = 0; m_exp = 1; m_errc = 0; m_wrapc = 0;
      end else if (v) begin
         if (m_mode == 0) begin
            if (legal(c)) begin m_mode = 1; m_run = 1; m_exp = nxt(c); end
         end else if (m_mode == 1) begin
            if (c == m_exp) begin
               m_run++; m_exp = nxt(c);
               if (m_run == LOCK_LEN) begin m_mode = 2; m_miss = 0; end
            end else if (legal(c)) begin
               m_run = 1; m_exp = nxt(c);
            end else begin
               m_mode = 0; m_run = 0;
            end
         end else begin
            if (c == m_exp) begin
               m_exp = nxt(c); m_miss = 0;
               if (c == 9) begin m_wrap = 1; m_wrapc = (m_wrapc + 1) % 256; end
            end else begin
               m_err = 1; m_errc = (m_errc < 255) ? m_errc + 1 : 255;
               m_exp = nxt(m_exp); m_miss++;
               if (m_miss == MAX_ERR) begin m_mode = 0; m_run = 0; m_miss = 0; end
            end
         end
      end
   endtask

   task automatic send(input bit r, input bit v, input int c);
      reset = r; valid_in = v; Count_in = 4'(c);
      @(posedge Clk);
      model(r, v, c);
      @(negedge Clk);
   endtask

   always @(negedge Clk) begin
      if (chk_en) begin
         check("locked",     int'(locked),     int'(m_mode == 2));
         check("error",      int'(error),      int'(m_err));
         check("wrap",       int'(wrap),       int'(m_wrap));
         check("expected",   int'(expected),   m_exp);
         check("err_count",  int'(err_count),  m_errc);
         check("wrap_count", int'(wrap_count), m_wrapc);
      end
   end

   initial begin
      int w0;
      // Reset held two cycles with a valid legal sample present
      @(posedge Clk); model(1, 1, 5); @(negedge Clk);
      chk_en = 1'b1;
      send(1, 1, 5);
      check("rst_locked", int'(locked), 0);
      check("rst_expected", int'(expected), 1);
      check("rst_errc", int'(err_count), 0);
      check("rst_wrapc", int'(wrap_count), 0);
      check("rst_error", int'(error), 0);
      check("rst_wrap", int'(wrap), 0);

      // Lock acquisition, then a wrap
      send(0, 1, 3); send(0, 1, 5);
      check("prelock", int'(locked), 0);
      send(0, 1, 7);
      check("lock_rise", int'(locked), 1);
      check("lock_exp", int'(expected), 9);
      send(0, 1, 9);
      check("wrap_pulse", int'(wrap), 1);
      check("wrap_cnt1", int'(wrap_count), 1);
      send(0, 1, 1);
      check("wrap_drop", int'(wrap), 0);
      check("exp_after1", int'(expected), 3);

      // Flywheel through a single glitch
      send(0, 1, 3);
      send(0, 1, 4);
      check("gl_err", int'(error), 1);
      check("gl_errc", int'(err_count), 1);
      check("gl_exp", int'(expected), 7);
      send(0, 1, 7);
      check("gl_locked", int'(locked), 1);
      check("gl_errdrop", int'(error), 0);

      // Two consecutive misses drop lock, then relock
      send(0, 1, 9);
      check("ll_exp", int'(expected), 1);
      send(0, 1, 2);
      check("ll_locked1", int'(locked), 1);
      send(0, 1, 8);
      check("ll_err2", int'(error), 1);
      check("ll_locked0", int'(locked), 0);
      check("ll_errc", int'(err_count), 3);
      send(0, 1, 3); send(0, 1, 5); send(0, 1, 7);
      check("relock", int'(locked), 1);
      check("relock_errc", int'(err_count), 3);

      // Illegal and mismatched samples while searching / locking
      send(0, 1, 8); send(0, 1, 0);
      check("srch", int'(locked), 0);
      send(0, 1, 12); send(0, 1, 3); send(0, 1, 7); send(0, 1, 9);
      send(0, 1, 15); send(0, 1, 1); send(0, 1, 3); send(0, 1, 5);
      check("relock2", int'(locked), 1);
      check("relock2_exp", int'(expected), 7);

      // Error counter saturation via glitch/recover pairs
      for (int i = 0; i < 260; i++) begin
         send(0, 1, 0);
         send(0, 1, m_exp);
      end
      check("sat_errc", int'(err_count), 255);
      check("sat_locked", int'(locked), 1);

      // 256 full cycles bring wrap_count back to its starting value
      w0 = m_wrapc;
      for (int i = 0; i < 256 * 5; i++) send(0, 1, m_exp);
      check("wrap_roll", int'(wrap_count), w0);

      // Gap in valid_in holds everything
      for (int i = 0; i < 10; i++) send(0, 0, 4'hF);
      check("gap_locked", int'(locked), 1);

      // Reset coincident with a valid 9
      while (m_exp != 9) send(0, 1, m_exp);
      send(1, 1, 9);
      check("rst9_wrap", int'(wrap), 0);
      check("rst9_locked", int'(locked), 0);
      check("rst9_exp", int'(expected), 1);
      check("rst9_errc", int'(err_count), 0);
      check("rst9_wrapc", int'(wrap_count), 0);
      send(0, 1, 9);
      check("post_rst_exp", int'(expected), 1);

      chk_en = 1'b0;
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
